// File: rtl/lp805x_rand_sched.sv
// lp805x_rand_sched
// Round-robin front-end that shares one 32-bit pseudo-random core among NREQ
// requesters. Each draw follows the same sequence: grant, run the core for
// RUN_CYC clocks, sample the word, then hold it until the winner acks.
// Reseed requests take priority over data requests, but are only serviced
// between draws.
// Optional ack timeout: define LP805X_RAND_SCHED_TMO_EN.
module lp805x_rand_sched #(
    parameter int NREQ    = 4,
    parameter int RUN_CYC = 4,
    parameter int TMO_CYC = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req,
    input  logic [NREQ-1:0] ack,
    output logic [NREQ-1:0] gnt,
    output logic [NREQ-1:0] rvalid,
    output logic [31:0]     rdata,
    input  logic            seed_req,
    input  logic [31:0]     seed_data,
    output logic            seed_done,
    output logic            rng_loadseed,
    output logic [31:0]     rng_seed,
    output logic            rng_run,
    input  logic [31:0]     rng_number,
    output logic            busy,
    output logic            tmo_err
);

    localparam int IW = $clog2(NREQ);

    // Stop elaboration on a configuration outside the supported ranges.
    if (NREQ < 2 || NREQ > 8 || RUN_CYC < 1 || RUN_CYC > 15 ||
        TMO_CYC < 1 || TMO_CYC > 255) begin : g_bad_cfg
        $error("lp805x_rand_sched: parameter out of range");
    end

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SEED   = 3'd1,
        RUN    = 3'd2,
        SAMPLE = 3'd3,
        HOLD   = 3'd4
    } state_t;

    state_t          state_reg, state_next;
    logic [IW-1:0]   ptr_reg, ptr_next;
    logic [IW-1:0]   win_reg, win_next;
    logic [NREQ-1:0] gnt_reg, gnt_next;
    logic [31:0]     rdata_reg, rdata_next;
    logic [31:0]     seed_reg, seed_next;
    logic [3:0]      run_cnt_reg, run_cnt_next;
    logic            seed_done_reg, seed_done_next;

    // Arbitration signals
    logic [2*NREQ-1:0] req_dbl;
    logic [NREQ-1:0]   req_rot;
    logic [NREQ-1:0]   arb_onehot;
    logic [IW-1:0]     arb_win;
    int                arb_off;
    int                arb_sum;

    logic [IW-1:0]     win_inc;
    logic              ack_win;
    logic              seed_pend;

    // Doubling the request vector lets a plain right shift rotate it so
    // that bit 0 corresponds to the current round-robin pointer.
    assign req_dbl = {req, req};
    assign req_rot = NREQ'(req_dbl >> ptr_reg);

    // Lowest set bit of the rotated vector is the winner's offset from ptr.
    always_comb begin
        arb_off = 0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req_rot[k]) begin
                arb_off = k;
            end
        end
        arb_sum = int'(ptr_reg) + arb_off;
        if (arb_sum >= NREQ) begin
            arb_sum = arb_sum - NREQ;
        end
        arb_win = IW'(arb_sum);
    end

    // One-hot grant for the arbitration winner, and rvalid qualified by HOLD.
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_lane
        assign arb_onehot[gi] = (arb_win == IW'(gi));
        assign rvalid[gi]     = (state_reg == HOLD) && gnt_reg[gi];
    end

    // Only the granted requester's ack bit counts; gnt_reg is one-hot.
    assign ack_win = |(ack & gnt_reg);

    // Pointer moves one past the requester that just finished.
    assign win_inc = (win_reg == IW'(NREQ - 1)) ? '0 : win_reg + IW'(1);

    // A requester keeps seed_req high until it sees seed_done, so the request
    // is masked in the cycle seed_done is shown to avoid a second reseed.
    assign seed_pend = seed_req && !seed_done_reg;

`ifdef LP805X_RAND_SCHED_TMO_EN
    logic [7:0] tmo_cnt_reg, tmo_cnt_next;
    logic       tmo_fire;

    // Timeout fires on the last allowed HOLD cycle if the winner stays silent.
    assign tmo_fire = (state_reg == HOLD) && !ack_win &&
                      (tmo_cnt_reg == 8'(TMO_CYC - 1));
    assign tmo_err  = tmo_fire;
`else
    assign tmo_err  = 1'b0;
`endif

    // Next-state and datapath update for the draw sequencer.
    always_comb begin
        state_next     = state_reg;
        ptr_next       = ptr_reg;
        win_next       = win_reg;
        gnt_next       = gnt_reg;
        rdata_next     = rdata_reg;
        seed_next      = seed_reg;
        run_cnt_next   = run_cnt_reg;
        seed_done_next = 1'b0;
`ifdef LP805X_RAND_SCHED_TMO_EN
        tmo_cnt_next   = tmo_cnt_reg;
`endif
        case (state_reg)
            IDLE: begin
                if (seed_pend) begin
                    seed_next  = seed_data;
                    state_next = SEED;
                end else if (|req) begin
                    win_next     = arb_win;
                    gnt_next     = arb_onehot;
                    run_cnt_next = 4'(RUN_CYC - 1);
                    state_next   = RUN;
                end
            end
            SEED: begin
                seed_done_next = 1'b1;
                state_next     = IDLE;
            end
            RUN: begin
                if (run_cnt_reg == 4'd0) begin
                    state_next = SAMPLE;
                end else begin
                    run_cnt_next = run_cnt_reg - 4'd1;
                end
            end
            SAMPLE: begin
                rdata_next = rng_number;
                state_next = HOLD;
`ifdef LP805X_RAND_SCHED_TMO_EN
                tmo_cnt_next = 8'd0;
`endif
            end
            HOLD: begin
                if (ack_win) begin
                    gnt_next   = '0;
                    ptr_next   = win_inc;
                    state_next = IDLE;
                end
`ifdef LP805X_RAND_SCHED_TMO_EN
                else if (tmo_fire) begin
                    gnt_next   = '0;
                    ptr_next   = win_inc;
                    state_next = IDLE;
                end else begin
                    tmo_cnt_next = tmo_cnt_reg + 8'd1;
                end
`endif
            end
            default: begin
                gnt_next   = '0;
                state_next = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg     <= IDLE;
            ptr_reg       <= '0;
            win_reg       <= '0;
            gnt_reg       <= '0;
            rdata_reg     <= '0;
            seed_reg      <= '0;
            run_cnt_reg   <= '0;
            seed_done_reg <= 1'b0;
`ifdef LP805X_RAND_SCHED_TMO_EN
            tmo_cnt_reg   <= '0;
`endif
        end else begin
            state_reg     <= state_next;
            ptr_reg       <= ptr_next;
            win_reg       <= win_next;
            gnt_reg       <= gnt_next;
            rdata_reg     <= rdata_next;
            seed_reg      <= seed_next;
            run_cnt_reg   <= run_cnt_next;
            seed_done_reg <= seed_done_next;
`ifdef LP805X_RAND_SCHED_TMO_EN
            tmo_cnt_reg   <= tmo_cnt_next;
`endif
        end
    end

    assign gnt          = gnt_reg;
    assign rdata        = rdata_reg;
    assign seed_done    = seed_done_reg;
    assign rng_loadseed = (state_reg == SEED);
    assign rng_seed     = seed_reg;
    assign rng_run      = (state_reg == RUN);
    assign busy         = (state_reg != IDLE);

endmodule

// File: tb/tb_lp805x_rand_sched.sv
// Testbench for lp805x_rand_sched: directed steps plus randomized draws,
// checked against a transaction-level round-robin / latency model.
module tb_lp805x_rand_sched;

    localparam int NREQ    = 4;
    localparam int RUN_CYC = 4;
    localparam int TMO_CYC = 8;

    logic            clk = 1'b0;
    logic            rst;
    logic [NREQ-1:0] req;
    logic [NREQ-1:0] ack;
    logic [NREQ-1:0] gnt;
    logic [NREQ-1:0] rvalid;
    logic [31:0]     rdata;
    logic            seed_req;
    logic [31:0]     seed_data;
    logic            seed_done;
    logic            rng_loadseed;
    logic [31:0]     rng_seed;
    logic            rng_run;
    logic [31:0]     rng_number;
    logic            busy;
    logic            tmo_err;

    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;
    int model_ptr = 0;

    lp805x_rand_sched #(
        .NREQ   (NREQ),
        .RUN_CYC(RUN_CYC),
        .TMO_CYC(TMO_CYC)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .ack         (ack),
        .gnt         (gnt),
        .rvalid      (rvalid),
        .rdata       (rdata),
        .seed_req    (seed_req),
        .seed_data   (seed_data),
        .seed_done   (seed_done),
        .rng_loadseed(rng_loadseed),
        .rng_seed    (rng_seed),
        .rng_run     (rng_run),
        .rng_number  (rng_number),
        .busy        (busy),
        .tmo_err     (tmo_err)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one clock; the random core model presents a fresh word each cycle.
    task automatic tick();
        @(posedge clk);
        #1;
        rng_number = $urandom();
    endtask

    function automatic logic [31:0] ctl();
        return 32'({gnt, rvalid, seed_done, rng_loadseed, rng_run, busy, tmo_err});
    endfunction

    // Round-robin reference: first requesting index at or after model_ptr.
    function automatic int rr_pick(input logic [NREQ-1:0] r);
        for (int k = 0; k < NREQ; k++) begin
            if (r[(model_ptr + k) % NREQ]) return (model_ptr + k) % NREQ;
        end
        return 0;
    endfunction

    function automatic logic [NREQ-1:0] onehot(input int w);
        logic [NREQ-1:0] v;
        v = '0;
        v[w] = 1'b1;
        return v;
    endfunction

    // Called in an IDLE cycle; returns in the first HOLD cycle.
    task automatic start_draw(input logic [NREQ-1:0] reqv, input bit drop, input bit seed_mid,
                              input logic [31:0] seedv, output int w, output logic [31:0] word);
        logic [NREQ-1:0] w1h;
        w   = rr_pick(reqv);
        w1h = onehot(w);
        req = reqv;
        tick();
        check("gnt_t1", 32'(gnt), 32'(w1h));
        check("busy_t1", 32'(busy), 1);
        if (drop) req = reqv & ~w1h;
        for (int i = 1; i <= RUN_CYC; i++) begin
            check("rng_run", 32'(rng_run), 1);
            check("rvalid_run", 32'(rvalid), 0);
            if (seed_mid && i == 1) begin
                seed_req  = 1'b1;
                seed_data = seedv;
            end
            ack = NREQ'($urandom());
            tick();
        end
        check("run_low_sample", 32'(rng_run), 0);
        check("rvalid_sample", 32'(rvalid), 0);
        check("gnt_sample", 32'(gnt), 32'(w1h));
        word = rng_number;
        ack  = NREQ'($urandom());
        tick();
        check("rvalid_hold", 32'(rvalid), 32'(w1h));
        check("rdata_hold", rdata, word);
        check("tmo_h0", 32'(tmo_err), 0);
    endtask

    // Called in the first HOLD cycle; waits, acks, returns in the IDLE cycle.
    task automatic finish_ack(input int w, input logic [31:0] word, input int wait_cyc);
        logic [NREQ-1:0] w1h;
        w1h = onehot(w);
        for (int k = 0; k < wait_cyc; k++) begin
            ack = NREQ'($urandom()) & ~w1h;
            tick();
            check("rvalid_wait", 32'(rvalid), 32'(w1h));
            check("rdata_stable", rdata, word);
            check("tmo_wait", 32'(tmo_err), 0);
        end
        ack = w1h | (NREQ'($urandom()) & ~w1h);
        tick();
        check("after_ack", ctl(), 0);
        ack = '0;
        model_ptr = (w + 1) % NREQ;
        $display("draw: winner=%0d word=%h wait=%0d next_ptr=%0d", w, word, wait_cyc, model_ptr);
    endtask

    // Called in an IDLE cycle; returns in the IDLE cycle that shows seed_done.
    task automatic seed_seq(input logic [31:0] seedv, input bit raise);
        if (raise) begin
            seed_req  = 1'b1;
            seed_data = seedv;
        end
        check("busy_pre_seed", 32'(busy), 0);
        tick();
        check("loadseed_on", 32'(rng_loadseed), 1);
        check("rng_seed", rng_seed, seedv);
        check("gnt_seed", 32'(gnt), 0);
        check("busy_seed", 32'(busy), 1);
        check("seed_done_early", 32'(seed_done), 0);
        tick();
        check("loadseed_off", 32'(rng_loadseed), 0);
        check("seed_done", 32'(seed_done), 1);
        check("busy_after_seed", 32'(busy), 0);
        check("gnt_after_seed", 32'(gnt), 0);
        check("rng_seed_hold", rng_seed, seedv);
        seed_req  = 1'b0;
        seed_data = $urandom();
        $display("seed: value=%h", seedv);
    endtask

    initial begin
        int w;
        logic [31:0] word;
        logic [NREQ-1:0] reqv;

        rst        = 1'b0;
        req        = '0;
        ack        = '0;
        seed_req   = 1'b0;
        seed_data  = '0;
        rng_number = $urandom();

        // Reset held for three cycles
        tick(); tick(); tick();
        check("rst_ctl", ctl(), 0);
        check("rst_rdata", rdata, 0);
        check("rst_seed", rng_seed, 0);
        rst = 1'b1;
        tick();
        check("idle_ctl", ctl(), 0);
        $display("reset: released");

        // Reseed from IDLE, then one idle cycle with seed_done clear
        seed_seq(32'h1234_5678, 1'b1);
        tick();
        check("seed_done_pulse", 32'(seed_done), 0);
        check("idle_after_seed", ctl(), 0);

        // Round-robin with all requesters held: order 0,1,2,3,0
        for (int n = 0; n < 5; n++) begin
            start_draw(4'b1111, 1'b0, 1'b0, 32'h0, w, word);
            check("rr_order", w, n % NREQ);
            finish_ack(w, word, 1);
        end
        req = '0;
        tick();

        // Single draw for requester 2, ack two cycles into HOLD
        start_draw(4'b0100, 1'b0, 1'b0, 32'h0, w, word);
        finish_ack(w, word, 2);
        req = '0;

        // Reseed raised during a draw for requester 1
        start_draw(4'b0010, 1'b0, 1'b1, 32'hCAFE_F00D, w, word);
        finish_ack(w, word, 1);
        req = 4'b1111;
        seed_seq(32'hCAFE_F00D, 1'b0);
        start_draw(4'b1111, 1'b0, 1'b0, 32'h0, w, word);
        check("ptr_after_seed", w, 2);
        finish_ack(w, word, 0);

        // Simultaneous seed_req and req: seed first, then arbitration
        req = 4'b0011;
        seed_seq(32'hA5A5_0F0F, 1'b1);
        start_draw(4'b0011, 1'b0, 1'b0, 32'h0, w, word);
        finish_ack(w, word, 3);

        // Requester 3 drops req during RUN; stray acks while it holds rvalid
        start_draw(4'b1000, 1'b1, 1'b0, 32'h0, w, word);
        ack = 4'b0001;
        tick();
        check("stray_ack_rvalid", 32'(rvalid), 32'(4'b1000));
        check("stray_ack_rdata", rdata, word);
        finish_ack(w, word, 2);

        // Reset in the middle of RUN aborts the draw
        req = 4'b0110;
        tick();
        check("pre_abort_busy", 32'(busy), 1);
        tick();
        rst = 1'b0;
        tick();
        check("abort_ctl", ctl(), 0);
        check("abort_rdata", rdata, 0);
        check("abort_seed", rng_seed, 0);
        rst = 1'b1;
        req = '0;
        model_ptr = 0;
        for (int k = 0; k < 6; k++) begin
            tick();
            check("abort_no_rvalid", 32'(rvalid), 0);
        end
        $display("reset: mid-draw abort");

        // Randomized draws
        for (int n = 0; n < 24; n++) begin
            bit drop;
            bit smid;
            logic [31:0] sv;
            reqv = NREQ'($urandom_range(1, (1 << NREQ) - 1));
            drop = ($urandom_range(0, 3) == 0);
            smid = ($urandom_range(0, 4) == 0);
            sv   = $urandom();
            start_draw(reqv, drop, smid, sv, w, word);
            finish_ack(w, word, $urandom_range(0, 5));
            if (smid) seed_seq(sv, 1'b0);
        end

        // No ack in HOLD
        start_draw(4'b1111, 1'b0, 1'b0, 32'h0, w, word);
`ifdef LP805X_RAND_SCHED_TMO_EN
        for (int k = 0; k < TMO_CYC - 1; k++) begin
            check("tmo_quiet", 32'(tmo_err), 0);
            check("tmo_rvalid", 32'(rvalid), 32'(onehot(w)));
            ack = NREQ'($urandom()) & ~onehot(w);
            tick();
        end
        check("tmo_pulse", 32'(tmo_err), 1);
        check("tmo_rvalid_last", 32'(rvalid), 32'(onehot(w)));
        ack = '0;
        tick();
        check("tmo_after", ctl(), 0);
        model_ptr = (w + 1) % NREQ;
        $display("timeout: winner=%0d dropped", w);
`else
        for (int k = 0; k < 120; k++) begin
            ack = NREQ'($urandom()) & ~onehot(w);
            tick();
            check("long_hold_rvalid", 32'(rvalid), 32'(onehot(w)));
            check("long_hold_tmo", 32'(tmo_err), 0);
        end
        finish_ack(w, word, 0);
`endif
        start_draw(4'b1111, 1'b0, 1'b0, 32'h0, w, word);
        finish_ack(w, word, 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
